// File: rtl/graying_pkg.sv
// Shared mode encodings and Q0.16 weighting coefficients for the streaming
// RGB-to-gray converter.
package graying_pkg;

  localparam logic [1:0] MODE_BT601 = 2'd0;
  localparam logic [1:0] MODE_BT709 = 2'd1;
  localparam logic [1:0] MODE_AVG   = 2'd2;
  localparam logic [1:0] MODE_MAX   = 2'd3;

  // Each weighted triple sums to 65536, so full-scale white maps to full scale.
  localparam logic [16:0] COEF_601_R = 17'd19595;
  localparam logic [16:0] COEF_601_G = 17'd38470;
  localparam logic [16:0] COEF_601_B = 17'd7471;
  localparam logic [16:0] COEF_709_R = 17'd13933;
  localparam logic [16:0] COEF_709_G = 17'd46871;
  localparam logic [16:0] COEF_709_B = 17'd4732;
  localparam logic [16:0] COEF_AVG_R = 17'd21846;
  localparam logic [16:0] COEF_AVG_G = 17'd21845;
  localparam logic [16:0] COEF_AVG_B = 17'd21845;

  typedef struct packed {
    logic [16:0] r;
    logic [16:0] g;
    logic [16:0] b;
  } coef_t;

  // Max-channel mode does not use the multipliers, so it gets all-zero weights.
  function automatic coef_t get_coefs(input logic [1:0] mode);
    coef_t c;
    c = '0;
    case (mode)
      MODE_BT601: begin
        c.r = COEF_601_R;
        c.g = COEF_601_G;
        c.b = COEF_601_B;
      end
      MODE_BT709: begin
        c.r = COEF_709_R;
        c.g = COEF_709_G;
        c.b = COEF_709_B;
      end
      MODE_AVG: begin
        c.r = COEF_AVG_R;
        c.g = COEF_AVG_G;
        c.b = COEF_AVG_B;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/graying_pipe_stage.sv
// One valid/ready pipeline register; it loads whenever it is empty or its
// content is being taken by the next stage, so bubbles collapse.
module graying_pipe_stage
  import graying_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         ready_o,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  input  logic         ready_i
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign ready_o = !valid_q || ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ready_o) begin
      valid_d = valid_i;
      if (valid_i) data_d = data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/graying_stream.sv
// Three-stage RGB-to-gray converter with per-pixel mode, full valid/ready
// backpressure, last-flag passthrough and a per-frame accepted-pixel counter.
module graying_stream
  import graying_pkg::*;
#(
  parameter int COLOR_WIDTH = 8,
  parameter int FRAC_BITS   = 16,
  parameter int CNT_WIDTH   = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3*COLOR_WIDTH-1:0] in_data,
  input  logic [1:0]               in_mode,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COLOR_WIDTH-1:0]   out_data,
  output logic                     out_last,
  output logic [CNT_WIDTH-1:0]     pix_cnt
);

  localparam int CW  = COLOR_WIDTH;
  localparam int PW  = CW + FRAC_BITS;
  localparam int AW  = CW + FRAC_BITS + 2;
  localparam int S1W = 2 + 3 * PW;
  localparam int S2W = 1 + AW;
  localparam int S3W = 1 + CW;
  localparam logic [AW-1:0] ROUND = AW'(1) << (FRAC_BITS - 1);

  logic [CW-1:0]  inR, inG, inB, maxVal;
  logic [PW-1:0]  prodR, prodG, prodB;
  coef_t          coefs;
  logic           isMax;
  logic [S1W-1:0] s1In, s1Out;
  logic [S2W-1:0] s2In, s2Out;
  logic [S3W-1:0] s3In, s3Out;
  logic           s1Valid, s2Valid, s3Valid;
  logic           s1Ready, s2Ready, s3Ready;
  logic [PW-1:0]  s1R, s1G, s1B;
  logic [AW-1:0]  acc, s2Acc;
  logic [CW+1:0]  shifted;
  logic [CW-1:0]  gray;
  logic           unusedFrac;
  logic [CNT_WIDTH-1:0] pixCnt_q, pixCnt_d;

  // Max mode stores max*2^FRAC_BITS so the later stages share one datapath.
  always_comb begin
    inR    = in_data[3*CW-1:2*CW];
    inG    = in_data[2*CW-1:CW];
    inB    = in_data[CW-1:0];
    coefs  = get_coefs(in_mode);
    isMax  = (in_mode == MODE_MAX);
    maxVal = inR;
    if (inG > maxVal) maxVal = inG;
    if (inB > maxVal) maxVal = inB;
    if (isMax) begin
      prodR = {maxVal, {FRAC_BITS{1'b0}}};
      prodG = '0;
      prodB = '0;
    end else begin
      prodR = {{FRAC_BITS{1'b0}}, inR} * {{(PW-17){1'b0}}, coefs.r};
      prodG = {{FRAC_BITS{1'b0}}, inG} * {{(PW-17){1'b0}}, coefs.g};
      prodB = {{FRAC_BITS{1'b0}}, inB} * {{(PW-17){1'b0}}, coefs.b};
    end
    s1In = {in_last, isMax, prodR, prodG, prodB};
  end

  always_comb begin
    s1R  = s1Out[3*PW-1:2*PW];
    s1G  = s1Out[2*PW-1:PW];
    s1B  = s1Out[PW-1:0];
    acc  = {2'b00, s1R} + {2'b00, s1G} + {2'b00, s1B};
    if (!s1Out[S1W-2]) acc = acc + ROUND;
    s2In = {s1Out[S1W-1], acc};
  end

  always_comb begin
    s2Acc   = s2Out[AW-1:0];
    shifted = s2Acc[AW-1:FRAC_BITS];
    gray    = (|shifted[CW+1:CW]) ? {CW{1'b1}} : shifted[CW-1:0];
    s3In    = {s2Out[S2W-1], gray};
  end

  assign unusedFrac = ^s2Acc[FRAC_BITS-1:0];

  graying_pipe_stage #(.W(S1W)) u_s1 (
    .clk(clk), .rst(rst),
    .valid_i(in_valid), .data_i(s1In), .ready_o(s1Ready),
    .valid_o(s1Valid), .data_o(s1Out), .ready_i(s2Ready)
  );

  graying_pipe_stage #(.W(S2W)) u_s2 (
    .clk(clk), .rst(rst),
    .valid_i(s1Valid), .data_i(s2In), .ready_o(s2Ready),
    .valid_o(s2Valid), .data_o(s2Out), .ready_i(s3Ready)
  );

  graying_pipe_stage #(.W(S3W)) u_s3 (
    .clk(clk), .rst(rst),
    .valid_i(s2Valid), .data_i(s3In), .ready_o(s3Ready),
    .valid_o(s3Valid), .data_o(s3Out), .ready_i(out_ready)
  );

  assign in_ready  = s1Ready;
  assign out_valid = s3Valid;
  assign out_data  = s3Out[CW-1:0];
  assign out_last  = s3Out[CW];

  // A last pixel restarts the count for the next frame.
  always_comb begin
    pixCnt_d = pixCnt_q;
    if (in_valid && in_ready) begin
      pixCnt_d = in_last ? '0 : pixCnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pixCnt_q <= '0;
    else     pixCnt_q <= pixCnt_d;
  end

  assign pix_cnt = pixCnt_q;

endmodule

// File: tb/tb_graying_stream.sv
// Directed checks of the gray converter: conversion values, latency, mode
// switching, backpressure, frame counting, reset and a 10-bit instance.
module tb_graying_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inValid = 1'b0, inReady, inLast = 1'b0;
  logic [23:0] inData = '0;
  logic [1:0]  inMode = '0;
  logic        outValid, outReady = 1'b1, outLast;
  logic [7:0]  outData;
  logic [23:0] pixCnt;

  logic        in10Valid = 1'b0, in10Ready, in10Last = 1'b0;
  logic [29:0] in10Data = '0;
  logic [1:0]  in10Mode = '0;
  logic        out10Valid, out10Ready = 1'b1, out10Last;
  logic [9:0]  out10Data;
  logic [23:0] pixCnt10;

  int passCnt = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;

  graying_stream dut (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_ready(inReady), .in_data(inData),
    .in_mode(inMode), .in_last(inLast),
    .out_valid(outValid), .out_ready(outReady), .out_data(outData),
    .out_last(outLast), .pix_cnt(pixCnt)
  );

  graying_stream #(.COLOR_WIDTH(10)) dut10 (
    .clk(clk), .rst(rst),
    .in_valid(in10Valid), .in_ready(in10Ready), .in_data(in10Data),
    .in_mode(in10Mode), .in_last(in10Last),
    .out_valid(out10Valid), .out_ready(out10Ready), .out_data(out10Data),
    .out_last(out10Last), .pix_cnt(pixCnt10)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    totalCnt++;
    if (outValid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", outValid);
    else passCnt++;
    totalCnt++;
    if (outData !== 8'd0) $display("[TB] FAIL reset_out_data got %0d want 0", outData);
    else passCnt++;
    totalCnt++;
    if (outLast !== 1'b0) $display("[TB] FAIL reset_out_last got %b want 0", outLast);
    else passCnt++;
    totalCnt++;
    if (pixCnt !== 24'd0) $display("[TB] FAIL reset_pix_cnt got %0d want 0", pixCnt);
    else passCnt++;
    @(negedge clk);
    rst = 1'b0;
    tick();
    totalCnt++;
    if (inReady !== 1'b1) $display("[TB] FAIL reset_in_ready got %b want 1", inReady);
    else passCnt++;
  endtask

  task automatic test_primaries();
    logic [23:0] pix [4] = '{24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF};
    logic [7:0]  expv [4] = '{8'd255, 8'd76, 8'd150, 8'd29};
    outReady = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k < 4) begin
        inValid = 1'b1; inData = pix[k]; inMode = 2'd0; inLast = 1'b0;
      end else inValid = 1'b0;
      tick();
      if (k >= 2 && k < 6) begin
        totalCnt++;
        if (outValid !== 1'b1) $display("[TB] FAIL primary_valid[%0d] got %b want 1", k - 2, outValid);
        else passCnt++;
        totalCnt++;
        if (outData !== expv[k-2]) $display("[TB] FAIL primary_data[%0d] got %0d want %0d", k - 2, outData, expv[k-2]);
        else passCnt++;
      end else begin
        totalCnt++;
        if (outValid !== 1'b0) $display("[TB] FAIL primary_idle[%0d] got %b want 0", k, outValid);
        else passCnt++;
      end
    end
  endtask

  task automatic test_mode_change();
    logic [23:0] pix [3] = '{24'hFF0000, {8'd30, 8'd60, 8'd90}, {8'd30, 8'd60, 8'd90}};
    logic [1:0]  mode [3] = '{2'd1, 2'd2, 2'd3};
    logic [7:0]  expv [3] = '{8'd54, 8'd60, 8'd90};
    for (int k = 0; k < 6; k++) begin
      if (k < 3) begin
        inValid = 1'b1; inData = pix[k]; inMode = mode[k]; inLast = 1'b0;
      end else inValid = 1'b0;
      tick();
      if (k >= 2 && k < 5) begin
        totalCnt++;
        if (outValid !== 1'b1 || outData !== expv[k-2])
          $display("[TB] FAIL mode_change[%0d] got v=%b d=%0d want v=1 d=%0d", k - 2, outValid, outData, expv[k-2]);
        else passCnt++;
      end
    end
  endtask

  task automatic test_back_to_back_backpressure();
    logic [23:0] pix [5] = '{{8'd11, 8'd5, 8'd2}, {8'd3, 8'd22, 8'd1}, {8'd0, 8'd0, 8'd33},
                             24'hFFFFFF, {8'd30, 8'd60, 8'd90}};
    logic [1:0]  mode [5] = '{2'd3, 2'd3, 2'd3, 2'd0, 2'd2};
    logic [7:0]  expv [5] = '{8'd11, 8'd22, 8'd33, 8'd255, 8'd60};
    int accepted = 0;
    int got = 0;
    logic took;
    outReady = 1'b0;
    for (int c = 0; c < 6; c++) begin
      inValid = 1'b1; inData = pix[accepted]; inMode = mode[accepted]; inLast = 1'b0;
      #1;
      took = inReady;
      tick();
      if (took) accepted++;
    end
    totalCnt++;
    if (accepted !== 3) $display("[TB] FAIL bp_accept_count got %0d want 3", accepted);
    else passCnt++;
    totalCnt++;
    if (inReady !== 1'b0) $display("[TB] FAIL bp_in_ready_full got %b want 0", inReady);
    else passCnt++;
    for (int c = 0; c < 3; c++) begin
      totalCnt++;
      if (outValid !== 1'b1 || outData !== expv[0])
        $display("[TB] FAIL bp_stall_hold[%0d] got v=%b d=%0d want v=1 d=%0d", c, outValid, outData, expv[0]);
      else passCnt++;
      tick();
    end
    outReady = 1'b1;
    #1;
    totalCnt++;
    if (inReady !== 1'b1) $display("[TB] FAIL bp_release_ready got %b want 1", inReady);
    else passCnt++;
    for (int c = 0; c < 20 && got < 5; c++) begin
      if (accepted < 5) begin
        inValid = 1'b1; inData = pix[accepted]; inMode = mode[accepted];
      end else inValid = 1'b0;
      #1;
      took = inValid && inReady;
      if (outValid) begin
        totalCnt++;
        if (outData !== expv[got]) $display("[TB] FAIL bp_drain[%0d] got %0d want %0d", got, outData, expv[got]);
        else passCnt++;
        got++;
      end
      tick();
      if (took) accepted++;
    end
    inValid = 1'b0;
    totalCnt++;
    if (got !== 5) $display("[TB] FAIL bp_delivered got %0d want 5", got);
    else passCnt++;
    tick();
    totalCnt++;
    if (outValid !== 1'b0) $display("[TB] FAIL bp_no_duplicate got %b want 0", outValid);
    else passCnt++;
  endtask

  task automatic test_frame();
    logic [23:0] cntExp [4] = '{24'd1, 24'd2, 24'd3, 24'd0};
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
    outReady = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k < 4) begin
        inValid = 1'b1; inData = {8'(k * 40), 8'd17, 8'd99}; inMode = 2'd0; inLast = (k == 3);
      end else begin
        inValid = 1'b0; inLast = 1'b0;
      end
      tick();
      if (k < 4) begin
        totalCnt++;
        if (pixCnt !== cntExp[k]) $display("[TB] FAIL frame_pix_cnt[%0d] got %0d want %0d", k, pixCnt, cntExp[k]);
        else passCnt++;
      end
      if (k >= 2 && k < 6) begin
        totalCnt++;
        if (outValid !== 1'b1 || outLast !== (k == 5))
          $display("[TB] FAIL frame_out_last[%0d] got v=%b l=%b want v=1 l=%b", k - 2, outValid, outLast, (k == 5));
        else passCnt++;
      end
    end
  endtask

  task automatic test_reset_midstream();
    int stale = 0;
    outReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      inValid = 1'b1; inData = {8'd200, 8'd100, 8'd50}; inMode = 2'd0; inLast = (k == 0);
      tick();
    end
    inValid = 1'b0; inLast = 1'b0;
    totalCnt++;
    if (outValid !== 1'b1 || outLast !== 1'b1 || pixCnt !== 24'd2)
      $display("[TB] FAIL midrst_before got v=%b l=%b cnt=%0d want v=1 l=1 cnt=2", outValid, outLast, pixCnt);
    else passCnt++;
    #1;
    rst = 1'b1;
    #1;
    totalCnt++;
    if (outValid !== 1'b0 || outData !== 8'd0 || outLast !== 1'b0)
      $display("[TB] FAIL midrst_outputs got v=%b d=%0d l=%b want 0 0 0", outValid, outData, outLast);
    else passCnt++;
    totalCnt++;
    if (pixCnt !== 24'd0) $display("[TB] FAIL midrst_pix_cnt got %0d want 0", pixCnt);
    else passCnt++;
    #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (outValid !== 1'b0) stale++;
    end
    totalCnt++;
    if (stale !== 0) $display("[TB] FAIL midrst_stale_valid got %0d cycles want 0", stale);
    else passCnt++;
  endtask

  function automatic logic [9:0] model10(input int r, input int g, input int b, input int mode);
    longint accv;
    int cr, cg, cb, m;
    cr = 0; cg = 0; cb = 0;
    case (mode)
      0: begin cr = 19595; cg = 38470; cb = 7471; end
      1: begin cr = 13933; cg = 46871; cb = 4732; end
      2: begin cr = 21846; cg = 21845; cb = 21845; end
      default: begin
        m = r;
        if (g > m) m = g;
        if (b > m) m = b;
        return 10'(m);
      end
    endcase
    accv = (longint'(r) * cr + longint'(g) * cg + longint'(b) * cb + 32768) >>> 16;
    if (accv > 1023) accv = 1023;
    return 10'(accv);
  endfunction

  task automatic test_width10();
    logic [29:0] pix [21];
    logic [1:0]  mode [21];
    logic [9:0]  expv [21];
    int r, g, b;
    int idx = 0;
    int got = 0;
    logic took;
    pix[0] = {10'd1023, 10'd1023, 10'd1023};
    mode[0] = 2'd0;
    expv[0] = 10'd1023;
    for (int i = 1; i < 21; i++) begin
      r = $urandom_range(0, 1023);
      g = $urandom_range(0, 1023);
      b = $urandom_range(0, 1023);
      mode[i] = 2'($urandom_range(0, 3));
      pix[i] = {10'(r), 10'(g), 10'(b)};
      expv[i] = model10(r, g, b, int'(mode[i]));
    end
    out10Ready = 1'b1;
    for (int c = 0; c < 60 && got < 21; c++) begin
      if (idx < 21) begin
        in10Valid = 1'b1; in10Data = pix[idx]; in10Mode = mode[idx];
      end else in10Valid = 1'b0;
      #1;
      took = in10Valid && in10Ready;
      if (out10Valid) begin
        totalCnt++;
        if (out10Data !== expv[got]) $display("[TB] FAIL w10_data[%0d] got %0d want %0d", got, out10Data, expv[got]);
        else passCnt++;
        got++;
      end
      tick();
      if (took) idx++;
    end
    in10Valid = 1'b0;
    totalCnt++;
    if (got !== 21) $display("[TB] FAIL w10_count got %0d want 21", got);
    else passCnt++;
  endtask

  initial begin
    test_reset();
    test_primaries();
    test_mode_change();
    test_back_to_back_backpressure();
    test_frame();
    test_reset_midstream();
    test_width10();
    $display("[TB] %0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
